goertzel_block_ctrl: RTL



---
 rtl/goertzel_block_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/goertzel_block_ctrl.sv
// Goertzel block controller: frames samples into N_SAMPLES blocks, drives the
// filter's clear/sample handshake, and computes tone power from final state.
// Optional feature macro: GOERTZEL_CTRL_AUTO_RESTART_EN (back-to-back blocks).
module goertzel_block_ctrl #(
    parameter int unsigned N_SAMPLES  = 205,
    parameter int          COEFF      = 0,
    parameter int unsigned COEFF_BITS = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic signed [15:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               filt_clr_o,
    output logic signed [15:0] filt_data_o,
    output logic               filt_valid_o,
    input  logic               filt_valid_i,
    input  logic signed [31:0] filt_s0_i,
    input  logic signed [31:0] filt_s1_i,
    output logic [63:0]        power_o,
    output logic               result_valid_o
);

    localparam int unsigned CNT_W   = $clog2(N_SAMPLES + 1);
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned STATE_W = 32;
    localparam int unsigned PROD_W  = 64;
    localparam int unsigned ACC_W   = 66;

    localparam logic signed [PROD_W-1:0] COEFF_W = 64'(COEFF);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        POW1,
        POW2,
        DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [STATE_W-1:0]  s0_q, s0_d;
    logic signed [STATE_W-1:0]  s1_q, s1_d;
    logic signed [PROD_W-1:0]   sq0_q, sq0_d;
    logic signed [PROD_W-1:0]   sq1_q, sq1_d;
    logic signed [STATE_W-1:0]  cs0_q, cs0_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       clr_q, clr_d;
    logic signed [DATA_W-1:0]   fdata_q, fdata_d;
    logic                       fvalid_q, fvalid_d;
    logic [PROD_W-1:0]          power_q, power_d;
    logic                       rvalid_q, rvalid_d;

    // Power datapath: sign-extended operands, products and 66-bit accumulator
    logic signed [PROD_W-1:0]   s0_ext, s1_ext, cs0_ext;
    logic signed [PROD_W-1:0]   coeff_prod, cross_prod;
    logic signed [ACC_W-1:0]    sq0_w, sq1_w, cross_w, acc;
    logic [PROD_W-1:0]          power_sat;

    assign s0_ext     = {{(PROD_W-STATE_W){s0_q[STATE_W-1]}}, s0_q};
    assign s1_ext     = {{(PROD_W-STATE_W){s1_q[STATE_W-1]}}, s1_q};
    assign cs0_ext    = {{(PROD_W-STATE_W){cs0_q[STATE_W-1]}}, cs0_q};
    assign coeff_prod = s0_ext * COEFF_W;
    assign cross_prod = cs0_ext * s1_ext;
    assign sq0_w      = {{(ACC_W-PROD_W){sq0_q[PROD_W-1]}}, sq0_q};
    assign sq1_w      = {{(ACC_W-PROD_W){sq1_q[PROD_W-1]}}, sq1_q};
    assign cross_w    = {{(ACC_W-PROD_W){cross_prod[PROD_W-1]}}, cross_prod};
    assign acc        = sq0_w + sq1_w - cross_w;

    // Clamp the signed accumulator into the unsigned 64-bit power range
    always_comb begin
        power_sat = acc[PROD_W-1:0];
        if (acc[ACC_W-1]) begin
            power_sat = '0;
        end else if (acc[PROD_W]) begin
            power_sat = '1;
        end
    end

    // Next-state and next-output logic; outputs decode the upcoming state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        sq0_d    = sq0_q;
        sq1_d    = sq1_q;
        cs0_d    = cs0_q;
        fdata_d  = fdata_q;
        power_d  = power_q;
        fvalid_d = 1'b0;
        rvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = FEED;
            end
            FEED: begin
                if (valid_i) begin
                    fdata_d  = data_i;
                    fvalid_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (filt_valid_i) begin
                    if (cnt_q == CNT_W'(N_SAMPLES)) begin
                        s0_d    = filt_s0_i;
                        s1_d    = filt_s1_i;
                        state_d = POW1;
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            POW1: begin
                sq0_d   = s0_ext * s0_ext;
                sq1_d   = s1_ext * s1_ext;
                cs0_d   = 32'(coeff_prod >>> COEFF_BITS);
                state_d = POW2;
            end
            POW2: begin
                power_d  = power_sat;
                rvalid_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
`ifdef GOERTZEL_CTRL_AUTO_RESTART_EN
                state_d = CLEAR;
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == FEED);
        busy_d  = (state_d != IDLE);
        clr_d   = (state_d == CLEAR);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            sq0_q    <= '0;
            sq1_q    <= '0;
            cs0_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            clr_q    <= 1'b0;
            fdata_q  <= '0;
            fvalid_q <= 1'b0;
            power_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            sq0_q    <= sq0_d;
            sq1_q    <= sq1_d;
            cs0_q    <= cs0_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            clr_q    <= clr_d;
            fdata_q  <= fdata_d;
            fvalid_q <= fvalid_d;
            power_q  <= power_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign ready_o        = ready_q;
    assign busy_o         = busy_q;
    assign filt_clr_o     = clr_q;
    assign filt_data_o    = fdata_q;
    assign filt_valid_o   = fvalid_q;
    assign power_o        = power_q;
    assign result_valid_o = rvalid_q;

endmodule
